// File: rtl/note_lane_engine.sv
// Falling-note lane engine: per-lane slot pools advanced by tick, scored by hit edges,
// with a combinational per-row coverage output for the renderer.
module note_lane_engine #(
    parameter int LANES  = 3,
    parameter int SLOTS  = 3,
    parameter int POS_W  = 10,
    parameter int Y_MAX  = 520,
    parameter int HALF_H = 20,
    parameter int HIT_LO = 440,
    parameter int HIT_HI = 480,
    parameter int CNT_W  = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         tick,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         pause,
    input  logic                         spawn_valid,
    input  logic [LANES-1:0]             spawn_mask,
    output logic                         spawn_ready,
    input  logic [LANES-1:0]             hit,
    input  logic [POS_W-1:0]             pixel_y,
    output logic [LANES-1:0]             lane_pix,
    output logic [1:0]                   state,
    output logic [CNT_W-1:0]             score,
    output logic [CNT_W-1:0]             misses,
    output logic [CNT_W-1:0]             drops,
    output logic [LANES*SLOTS-1:0]       active,
    output logic [LANES*SLOTS*POS_W-1:0] positions
);

    localparam int N = LANES * SLOTS;
    localparam logic [POS_W-1:0] YMax   = POS_W'(Y_MAX);
    localparam logic [POS_W-1:0] HitLo  = POS_W'(HIT_LO);
    localparam logic [POS_W-1:0] HitHi  = POS_W'(HIT_HI);
    localparam logic [POS_W-1:0] PosOne = POS_W'(1);
    localparam logic [POS_W:0]   HalfH  = (POS_W + 1)'(HALF_H);
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    typedef enum logic [1:0] {StIdle = 2'b00, StPlay = 2'b01, StPause = 2'b10} state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     active_q, active_d;
    logic [POS_W-1:0] pos_q [N];
    logic [POS_W-1:0] pos_d [N];
    logic [CNT_W-1:0] score_q, score_d, misses_q, misses_d, drops_q, drops_d;
    logic [LANES-1:0] hit_q;

    logic [N-1:0]     expire, hit_free, alloc;
    logic [CNT_W-1:0] miss_inc, score_inc, drop_inc;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start && !stop) state_d = StPlay;
            StPlay:  if (stop) state_d = StIdle; else if (pause) state_d = StPause;
            StPause: if (stop) state_d = StIdle; else if (!pause) state_d = StPlay;
            default: state_d = StIdle;
        endcase
    end

    assign spawn_ready = (state_q == StPlay);

    // Hit selection works on pre-tick positions; only the deepest in-window note per lane goes.
    always_comb begin
        logic             found;
        logic [POS_W-1:0] best;
        int               best_s;
        hit_free = '0;
        for (int l = 0; l < LANES; l++) begin
            found  = 1'b0;
            best   = '0;
            best_s = 0;
            for (int s = 0; s < SLOTS; s++) begin
                if (active_q[l*SLOTS+s] && pos_q[l*SLOTS+s] >= HitLo &&
                    pos_q[l*SLOTS+s] <= HitHi && (!found || pos_q[l*SLOTS+s] > best)) begin
                    found  = 1'b1;
                    best   = pos_q[l*SLOTS+s];
                    best_s = s;
                end
            end
            if (found && hit[l] && !hit_q[l]) hit_free[l*SLOTS+best_s] = 1'b1;
        end
    end

    // Allocation looks only at slots already free before this edge.
    always_comb begin
        logic placed;
        alloc    = '0;
        drop_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            placed = 1'b0;
            if (spawn_valid && spawn_ready && spawn_mask[l]) begin
                for (int s = 0; s < SLOTS; s++) begin
                    if (!placed && !active_q[l*SLOTS+s]) begin
                        alloc[l*SLOTS+s] = 1'b1;
                        placed           = 1'b1;
                    end
                end
                if (!placed) drop_inc = drop_inc + CntOne;
            end
        end
    end

    always_comb begin
        miss_inc  = '0;
        score_inc = '0;
        for (int i = 0; i < N; i++) begin
            expire[i] = active_q[i] && (pos_q[i] > YMax);
            if (expire[i]) miss_inc = miss_inc + CntOne;
            else if (hit_free[i]) score_inc = score_inc + CntOne;
        end
    end

    always_comb begin
        active_d = active_q;
        pos_d    = pos_q;
        score_d  = score_q;
        misses_d = misses_q;
        drops_d  = drops_q;
        if (state_q == StIdle && state_d == StPlay) begin
            active_d = '0;
            for (int i = 0; i < N; i++) pos_d[i] = '0;
            score_d  = '0;
            misses_d = '0;
            drops_d  = '0;
        end else if (state_q == StPlay) begin
            for (int i = 0; i < N; i++) begin
                if (expire[i] || hit_free[i]) begin
                    active_d[i] = 1'b0;
                    pos_d[i]    = '0;
                end else if (alloc[i]) begin
                    active_d[i] = 1'b1;
                    pos_d[i]    = '0;
                end else if (active_q[i] && tick) begin
                    pos_d[i] = pos_q[i] + PosOne;
                end
            end
            score_d  = sat_add(score_q, score_inc);
            misses_d = sat_add(misses_q, miss_inc);
            drops_d  = sat_add(drops_q, drop_inc);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            active_q <= '0;
            for (int i = 0; i < N; i++) pos_q[i] <= '0;
            score_q  <= '0;
            misses_q <= '0;
            drops_q  <= '0;
            hit_q    <= '0;
        end else begin
            state_q  <= state_d;
            active_q <= active_d;
            for (int i = 0; i < N; i++) pos_q[i] <= pos_d[i];
            score_q  <= score_d;
            misses_q <= misses_d;
            drops_q  <= drops_d;
            hit_q    <= hit;
        end
    end

    // Coverage band computed one bit wider so it neither underflows at the top nor wraps.
    always_comb begin
        logic [POS_W:0] p, lo, hi, y;
        lane_pix = '0;
        y        = {1'b0, pixel_y};
        for (int i = 0; i < N; i++) begin
            p  = {1'b0, pos_q[i]};
            lo = (p >= HalfH) ? p - HalfH : '0;
            hi = p + HalfH;
            if (active_q[i] && y >= lo && y <= hi) lane_pix[i / SLOTS] = 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) positions[i*POS_W +: POS_W] = pos_q[i];
    end

    assign state  = state_q;
    assign active = active_q;
    assign score  = score_q;
    assign misses = misses_q;
    assign drops  = drops_q;

endmodule

// File: tb/tb_note_lane_engine.sv
// Directed self-checking bench for note_lane_engine at default parameters.
module tb_note_lane_engine;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        tick, start, stop, pause, spawn_valid, spawn_ready;
    logic [2:0]  spawn_mask, hit, lane_pix;
    logic [9:0]  pixel_y;
    logic [1:0]  state;
    logic [7:0]  score, misses, drops;
    logic [8:0]  active;
    logic [89:0] positions;

    int n_checks = 0;
    int n_fail   = 0;

    note_lane_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .start      (start),
        .stop       (stop),
        .pause      (pause),
        .spawn_valid(spawn_valid),
        .spawn_mask (spawn_mask),
        .spawn_ready(spawn_ready),
        .hit        (hit),
        .pixel_y    (pixel_y),
        .lane_pix   (lane_pix),
        .state      (state),
        .score      (score),
        .misses     (misses),
        .drops      (drops),
        .active     (active),
        .positions  (positions)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [9:0] pos(input int idx);
        return positions[idx*10 +: 10];
    endfunction

    task automatic ticks(input int n);
        tick = 1'b1;
        cyc(n);
        tick = 1'b0;
    endtask

    task automatic spawn(input logic [2:0] m);
        spawn_valid = 1'b1;
        spawn_mask  = m;
        cyc();
        spawn_valid = 1'b0;
        spawn_mask  = '0;
    endtask

    task automatic restart();
        stop = 1'b1;
        cyc();
        stop  = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        {tick, start, stop, pause, spawn_valid} = '0;
        spawn_mask = '0;
        hit        = '0;
        pixel_y    = '0;
        cyc(2);
        check("rst_state", state, 2'b00);
        check("rst_active", active, 9'd0);
        check("rst_ready", spawn_ready, 1'b0);
        check("rst_counters", {score, misses, drops}, 24'd0);
        reset_n = 1'b1;
        cyc();

        // Two-lane spawn then five ticks
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("play_state", state, 2'b01);
        check("play_ready", spawn_ready, 1'b1);
        spawn(3'b101);
        ticks(5);
        check("spawn_active", active, 9'b001_000_001);
        check("spawn_pos0", pos(0), 10'd5);
        check("spawn_pos6", pos(6), 10'd5);

        // Overfill lane 0, then drive drops into saturation
        restart();
        check("restart_clear", active, 9'd0);
        repeat (4) spawn(3'b001);
        check("full_active", active, 9'b000_000_111);
        check("drop_one", drops, 8'd1);
        spawn_valid = 1'b1;
        spawn_mask  = 3'b011;
        cyc(300);
        spawn_valid = 1'b0;
        spawn_mask  = '0;
        check("drop_sat", drops, 8'd255);

        // Hit window scoring
        restart();
        spawn(3'b001);
        ticks(460);
        check("pos_460", pos(0), 10'd460);
        hit = 3'b001;
        cyc();
        check("hit_freed", active[0], 1'b0);
        check("hit_score", score, 8'd1);
        cyc();
        hit = 3'b000;
        cyc();
        hit = 3'b001;
        cyc();
        hit = 3'b000;
        check("hit_second", score, 8'd1);
        spawn(3'b001);
        ticks(430);
        hit = 3'b001;
        cyc();
        hit = 3'b000;
        check("hit_430_active", active[0], 1'b1);
        check("hit_430_score", score, 8'd1);

        // Expiry past the last row
        ticks(91);
        check("pos_521", pos(0), 10'd521);
        cyc();
        check("exp_freed", active[0], 1'b0);
        check("exp_pos", pos(0), 10'd0);
        check("exp_miss", misses, 8'd1);
        spawn(3'b001);
        check("exp_reuse", active[2:0], 3'b001);

        // Pause, resume, stop, restart
        restart();
        spawn(3'b001);
        ticks(100);
        pause = 1'b1;
        cyc();
        check("pause_state", state, 2'b10);
        check("pause_ready", spawn_ready, 1'b0);
        ticks(10);
        check("pause_hold", pos(0), 10'd100);
        pause = 1'b0;
        cyc();
        check("resume_state", state, 2'b01);
        ticks(1);
        check("resume_pos", pos(0), 10'd101);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        check("stop_state", state, 2'b00);
        check("stop_pos", pos(0), 10'd101);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("start_clear", {active, pos(0), misses}, '0);

        // Pixel coverage near the top, then async reset mid-sweep
        spawn(3'b010);
        ticks(10);
        check("pix_pos", pos(3), 10'd10);
        for (int y = 0; y <= 40; y++) begin
            pixel_y = 10'(y);
            #1;
            check($sformatf("pix_y%0d", y), lane_pix, (y <= 30) ? 3'b010 : 3'b000);
        end
        pixel_y = 10'd15;
        #1;
        check("pix_pre_rst", lane_pix, 3'b010);
        reset_n = 1'b0;
        #1;
        check("pix_rst", lane_pix, 3'b000);
        check("rst_mid_state", state, 2'b00);
        check("rst_mid_cnt", {score, misses, drops}, 24'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_lane_engine.md
NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

Interface
REQ-001 Parameter LANES, default 3, number of note lanes.
REQ-002 Parameter SLOTS, default 3, concurrent note slots per lane.
REQ-003 Parameter POS_W, default 10, position width in pixel rows.
REQ-004 Parameter Y_MAX, default 520, last valid row; a note whose position exceeds it is expired.
REQ-005 Parameter HALF_H, default 20, note half-height in rows.
REQ-006 Parameter HIT_LO / HIT_HI, default 440 / 480, inclusive hit window on note position.
REQ-007 Parameter CNT_W, default 8, width of score/miss/drop counters.
REQ-008 clk  in  1  single clock; all state on posedge clk.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 tick  in  1  one-cycle movement strobe; the only event that advances positions.
REQ-011 start / stop / pause  in  1 each  level controls, sampled every clk.
REQ-012 spawn_valid  in  1, spawn_mask  in  LANES, spawn_ready  out  1  note-row spawn handshake.
REQ-013 hit  in  LANES  player buttons, already synchronised, level.
REQ-014 pixel_y  in  POS_W, lane_pix  out  LANES  combinational per-lane "note covers this row".
REQ-015 state  out  2  IDLE=00, PLAY=01, PAUSE=10.
REQ-016 score, misses, drops  out  CNT_W each.
REQ-017 active  out  LANES*SLOTS, positions  out  LANES*SLOTS*POS_W; slot index = lane*SLOTS+slot.

Function
REQ-018 FSM: IDLE->PLAY when start=1; PLAY->PAUSE when pause=1; PAUSE->PLAY when pause=0; PLAY or PAUSE->IDLE when stop=1 (stop has priority over pause and start).
REQ-019 Entry to PLAY from IDLE clears all slots, positions and counters in the same cycle.
REQ-020 spawn_ready = 1 only in PLAY; transfer occurs when spawn_valid & spawn_ready on a clk edge.
REQ-021 On transfer, for each set bit l of spawn_mask, the lowest-index free slot of lane l is set active with position 0.
REQ-022 If lane l has no free slot on transfer, that lane's note is discarded and drops increments by 1 (multiple full lanes in one transfer add the count of full lanes).
REQ-023 In PLAY, on tick, each active slot position increases by 1; inactive slots hold.
REQ-024 An active slot whose position is > Y_MAX at a clk edge in PLAY becomes free, its position returns to 0, and misses increments by 1 per expired slot.
REQ-025 hit edge detection internal: a hit event is hit[l] 0->1 between consecutive clk edges; held buttons produce one event.
REQ-026 On a hit event in PLAY, if lane l has active slots with HIT_LO <= position <= HIT_HI, the one with largest position (lowest index on tie) is freed and score increments by 1; otherwise no effect.
REQ-027 Same-cycle tick and hit: hit window evaluated on pre-tick positions; freed slot does not advance.
REQ-028 A slot freed (expiry or hit) in a cycle is not allocatable by a spawn in that same cycle.
REQ-029 Counters saturate at 2^CNT_W-1; no wrap.
REQ-030 PAUSE and IDLE: positions, active, counters frozen; ticks, spawns, hit events ignored (edge detector still tracks hit).
REQ-031 lane_pix[l] = 1 iff some active slot of lane l has max(position-HALF_H,0) <= pixel_y <= position+HALF_H, computed at POS_W+1 bits with no underflow or overflow wrap.

Reset
REQ-032 reset_n=0 asynchronously forces state=IDLE, all active=0, positions=0, score=misses=drops=0, hit history=0; spawn_ready=0 and lane_pix=0 follow combinationally.
REQ-033 Reset asserted mid-PLAY discards all in-flight notes with no miss or drop counted.

Verification
REQ-034 start=1, spawn_mask=3'b101 transfer, 5 ticks -> slots 0 and 6 active, position 5; lane 1 idle; spawn_ready=1.
REQ-035 Lane 0 spawned 4 times with SLOTS=3, no ticks -> slots 0..2 active, drops=1.
REQ-036 One lane-0 note ticked to 460, hit[0] pulse -> slot freed, score=1; second pulse -> score stays 1; note at 430 hit -> unchanged.
REQ-037 Note ticked past 520 (521 reached) -> freed, misses=1; next spawn in lane reuses slot 0.
REQ-038 PLAY with note at 100, pause=1, 10 ticks -> position 100; pause=0, 1 tick -> 101; stop=1 -> IDLE, positions held; start -> all cleared.
REQ-039 Note at position 10, pixel_y sweep 0..40 -> lane_pix[l]=1 for rows 0..30 only; reset_n low mid-sweep -> lane_pix=0 immediately.
